// File: rtl/d_mem_req_ctrl.sv
// Load/store request controller: in-order request queue feeding a single-outstanding
// ready/ack data memory port, with one tagged response per request back to the LSU.
module d_mem_req_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_req_op,
  input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
  input  logic [DATA_WIDTH-1:0] lsu_req_data,
  input  logic [TAG_WIDTH-1:0]  lsu_req_tag,
  output logic                  lsu_resp_valid,
  input  logic                  lsu_resp_ready,
  output logic                  lsu_resp_op,
  output logic [DATA_WIDTH-1:0] lsu_resp_data,
  output logic [TAG_WIDTH-1:0]  lsu_resp_tag,
  output logic                  memory_req_valid,
  output logic                  memory_req_op,
  output logic [ADDR_WIDTH-1:0] memory_req_address,
  output logic [DATA_WIDTH-1:0] memory_req_data,
  input  logic                  memory_ready,
  input  logic                  memory_ack,
  input  logic [DATA_WIDTH-1:0] memory_data_return,
  output logic                  busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REQ      = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;
  localparam logic [1:0] RESP     = 2'd3;

  logic [1:0]                        state;
  logic                              run;
  logic [PW-1:0]                     wr_ptr, rd_ptr;
  logic [CW-1:0]                     count;
  logic [DEPTH-1:0]                  q_op;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0]  q_addr;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]  q_data;
  logic [DEPTH-1:0][TAG_WIDTH-1:0]   q_tag;
  logic                              iss_op;
  logic [ADDR_WIDTH-1:0]             iss_addr;
  logic [DATA_WIDTH-1:0]             iss_data;
  logic [TAG_WIDTH-1:0]              iss_tag;
  logic [DATA_WIDTH-1:0]             resp_data;
  logic                              has_entry, push, pop;

  // run keeps ready low during reset without a reset-to-output combinational path
  assign has_entry     = (count != '0);
  assign lsu_req_ready = run && (count != FULL);
  assign push          = lsu_req_valid && lsu_req_ready;
  assign pop           = has_entry && ((state == IDLE) || ((state == RESP) && lsu_resp_ready));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run    <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      q_op   <= '0;
      q_addr <= '0;
      q_data <= '0;
      q_tag  <= '0;
    end else begin
      run <= 1'b1;
      if (push) begin
        q_op[wr_ptr]   <= lsu_req_op;
        q_addr[wr_ptr] <= lsu_req_addr;
        q_data[wr_ptr] <= lsu_req_data;
        q_tag[wr_ptr]  <= lsu_req_tag;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Issue register doubles as the response op/tag source; it only reloads on pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      iss_op    <= 1'b0;
      iss_addr  <= '0;
      iss_data  <= '0;
      iss_tag   <= '0;
      resp_data <= '0;
    end else begin
      if (pop) begin
        iss_op   <= q_op[rd_ptr];
        iss_addr <= q_addr[rd_ptr];
        iss_data <= q_data[rd_ptr];
        iss_tag  <= q_tag[rd_ptr];
      end
      case (state)
        IDLE:     if (has_entry) state <= REQ;
        REQ:      if (memory_ready) state <= WAIT_ACK;
        WAIT_ACK: if (memory_ack) begin
          resp_data <= iss_op ? '0 : memory_data_return;
          state     <= RESP;
        end
        RESP:     if (lsu_resp_ready) state <= has_entry ? REQ : IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign memory_req_valid   = (state == REQ);
  assign memory_req_op      = iss_op;
  assign memory_req_address = iss_addr;
  assign memory_req_data    = iss_data;
  assign lsu_resp_valid     = (state == RESP);
  assign lsu_resp_op        = iss_op;
  assign lsu_resp_tag       = iss_tag;
  assign lsu_resp_data      = resp_data;
  assign busy               = has_entry || (state != IDLE);

endmodule

// File: tb/tb_d_mem_req_ctrl.sv
// Bench for d_mem_req_ctrl: directed vector table, multi-cycle corner sequences and
// randomized traffic scored against an in-order request/response memory model.
`timescale 1ns/1ps
module tb_d_mem_req_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_op;
  logic [31:0] lsu_req_addr, lsu_req_data;
  logic [3:0]  lsu_req_tag;
  logic        lsu_resp_valid, lsu_resp_ready, lsu_resp_op;
  logic [31:0] lsu_resp_data;
  logic [3:0]  lsu_resp_tag;
  logic        memory_req_valid, memory_req_op;
  logic [31:0] memory_req_address, memory_req_data;
  logic        memory_ready, memory_ack;
  logic [31:0] memory_data_return;
  logic        busy;

  d_mem_req_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TAG_WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_op(lsu_req_op),
    .lsu_req_addr(lsu_req_addr), .lsu_req_data(lsu_req_data), .lsu_req_tag(lsu_req_tag),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_op(lsu_resp_op),
    .lsu_resp_data(lsu_resp_data), .lsu_resp_tag(lsu_resp_tag),
    .memory_req_valid(memory_req_valid), .memory_req_op(memory_req_op),
    .memory_req_address(memory_req_address), .memory_req_data(memory_req_data),
    .memory_ready(memory_ready), .memory_ack(memory_ack),
    .memory_data_return(memory_data_return), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic op; logic [31:0] addr; logic [31:0] data; logic [3:0] tag; } req_t;
  typedef struct { logic op; logic [31:0] data; logic [3:0] tag; } rsp_t;
  typedef struct {
    logic op; logic [31:0] addr; logic [31:0] data; logic [3:0] tag;
    logic [31:0] ret; int mdly; int rdly; logic [31:0] exp_data;
  } vec_t;

  int n_cmp = 0, n_bad = 0;
  int n_push = 0, n_resp = 0, push_target = 0;
  int rdy_wait = -1, ack_wait = -1, resp_wait = -1;
  bit outst = 1'b0;
  logic [31:0] ack_val;
  req_t exp_mreq[$];
  rsp_t exp_resp[$];
  logic [31:0] refm [logic [31:0]];
  logic [31:0] devm [logic [31:0]];
  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h1357;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : dflt(a);
  endfunction
  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    return devm.exists(a) ? devm[a] : dflt(a);
  endfunction

  task automatic idle_inputs();
    lsu_req_valid = 0; lsu_req_op = 0; lsu_req_addr = 0; lsu_req_data = 0; lsu_req_tag = 0;
    lsu_resp_ready = 0; memory_ready = 0; memory_ack = 0; memory_data_return = 0;
  endtask

  task automatic clear_model();
    exp_mreq.delete(); exp_resp.delete();
    outst = 0; rdy_wait = -1; ack_wait = -1; resp_wait = -1;
  endtask

  // One clock of the scored environment: log handshakes that fire at the coming edge.
  task automatic tick();
    req_t r; rsp_t p, e;
    bit set_o, clr_o, ms, rs;
    logic [31:0] s_ma, s_md, s_rd;
    logic s_mo, s_ro;
    logic [3:0] s_rt;
    set_o = 0; clr_o = 0;
    if (lsu_req_valid && lsu_req_ready) begin
      r.op = lsu_req_op; r.addr = lsu_req_addr; r.data = lsu_req_data; r.tag = lsu_req_tag;
      exp_mreq.push_back(r);
      p.op = r.op; p.tag = r.tag;
      if (r.op) begin p.data = '0; refm[r.addr] = r.data; end
      else p.data = ref_rd(r.addr);
      exp_resp.push_back(p);
      n_push++;
    end
    if (memory_req_valid && memory_ready) begin
      chk("single_outstanding", outst, 0);
      chk("mreq_expected", exp_mreq.size() > 0, 1);
      if (exp_mreq.size() > 0) begin
        r = exp_mreq.pop_front();
        chk("mreq_op", memory_req_op, r.op);
        chk("mreq_addr", memory_req_address, r.addr);
        if (r.op) chk("mreq_data", memory_req_data, r.data);
      end
      if (memory_req_op) begin
        devm[memory_req_address] = memory_req_data;
        ack_val = $urandom;
      end else ack_val = dev_rd(memory_req_address);
      rdy_wait = -1;
      set_o = 1;
    end
    if (memory_ack && outst) clr_o = 1;
    if (lsu_resp_valid && lsu_resp_ready) begin
      n_resp++;
      chk("resp_expected", exp_resp.size() > 0, 1);
      if (exp_resp.size() > 0) begin
        e = exp_resp.pop_front();
        chk("resp_tag", lsu_resp_tag, e.tag);
        chk("resp_op", lsu_resp_op, e.op);
        chk("resp_data", lsu_resp_data, e.data);
      end
    end
    ms = memory_req_valid && !memory_ready;
    rs = lsu_resp_valid && !lsu_resp_ready;
    s_ma = memory_req_address; s_md = memory_req_data; s_mo = memory_req_op;
    s_rd = lsu_resp_data; s_ro = lsu_resp_op; s_rt = lsu_resp_tag;
    @(posedge clk); #1;
    if (clr_o) outst = 0;
    if (set_o) outst = 1;
    if (ms) begin
      chk("mreq_hold_valid", memory_req_valid, 1);
      chk("mreq_hold_addr", memory_req_address, s_ma);
      chk("mreq_hold_data", memory_req_data, s_md);
      chk("mreq_hold_op", memory_req_op, s_mo);
    end
    if (rs) begin
      chk("resp_hold_valid", lsu_resp_valid, 1);
      chk("resp_hold_data", lsu_resp_data, s_rd);
      chk("resp_hold_op", lsu_resp_op, s_ro);
      chk("resp_hold_tag", lsu_resp_tag, s_rt);
    end
    if (outst) chk("no_issue_while_outstanding", memory_req_valid, 0);
  endtask

  task automatic drive_mem(input bit hold, input int max_dly, input bit stray);
    memory_ack = 0;
    memory_data_return = $urandom;
    if (memory_req_valid && !outst && !hold) begin
      if (rdy_wait < 0) rdy_wait = $urandom_range(0, max_dly);
      memory_ready = (rdy_wait == 0);
      if (rdy_wait > 0) rdy_wait--;
    end else memory_ready = 0;
    if (outst) begin
      if (ack_wait < 0) ack_wait = $urandom_range(0, max_dly);
      if (ack_wait == 0) begin
        memory_ack = 1; memory_data_return = ack_val; ack_wait = -1;
      end else ack_wait--;
    end else if (stray && !memory_ready && $urandom_range(0, 5) == 0) memory_ack = 1;
  endtask

  task automatic drive_resp(input int max_hold);
    if (lsu_resp_valid) begin
      if (resp_wait < 0) resp_wait = $urandom_range(0, max_hold);
      if (resp_wait == 0) begin lsu_resp_ready = 1; resp_wait = -1; end
      else begin lsu_resp_ready = 0; resp_wait--; end
    end else lsu_resp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_lsu();
    logic [3:0] a4;
    a4 = 4'($urandom_range(0, 15));
    lsu_req_valid = (n_push < push_target) && ($urandom_range(0, 2) != 0);
    lsu_req_op    = 1'($urandom_range(0, 1));
    lsu_req_addr  = {26'h0, a4, 2'b00};
    lsu_req_data  = $urandom;
    lsu_req_tag   = 4'($urandom);
  endtask

  // Directed single transaction with exact cycle positions from the push edge.
  task automatic run_vec(input vec_t v, input string nm);
    lsu_req_valid = 1; lsu_req_op = v.op; lsu_req_addr = v.addr;
    lsu_req_data = v.data; lsu_req_tag = v.tag;
    @(posedge clk); #1;
    lsu_req_valid = 0;
    chk({nm, "_e0_mreq_valid"}, memory_req_valid, 0);
    chk({nm, "_e0_busy"}, busy, 1);
    @(posedge clk); #1;
    chk({nm, "_e1_mreq_valid"}, memory_req_valid, 1);
    chk({nm, "_e1_mreq_op"}, memory_req_op, v.op);
    chk({nm, "_e1_mreq_addr"}, memory_req_address, v.addr);
    if (v.op) chk({nm, "_e1_mreq_data"}, memory_req_data, v.data);
    for (int i = 0; i < v.mdly; i++) begin
      memory_ready = 0;
      memory_ack = (i == 0);
      @(posedge clk); #1;
      memory_ack = 0;
      chk({nm, "_stall_mreq_valid"}, memory_req_valid, 1);
      chk({nm, "_stall_mreq_addr"}, memory_req_address, v.addr);
      chk({nm, "_stall_resp_valid"}, lsu_resp_valid, 0);
    end
    memory_ready = 1;
    @(posedge clk); #1;
    memory_ready = 0;
    chk({nm, "_e2_mreq_valid"}, memory_req_valid, 0);
    chk({nm, "_e2_resp_valid"}, lsu_resp_valid, 0);
    memory_ack = 1; memory_data_return = v.ret;
    @(posedge clk); #1;
    memory_ack = 0; memory_data_return = $urandom;
    chk({nm, "_e3_resp_valid"}, lsu_resp_valid, 1);
    chk({nm, "_e3_resp_tag"}, lsu_resp_tag, v.tag);
    chk({nm, "_e3_resp_op"}, lsu_resp_op, v.op);
    chk({nm, "_e3_resp_data"}, lsu_resp_data, v.exp_data);
    for (int i = 0; i < v.rdly; i++) begin
      lsu_resp_ready = 0;
      @(posedge clk); #1;
      chk({nm, "_rstall_valid"}, lsu_resp_valid, 1);
      chk({nm, "_rstall_data"}, lsu_resp_data, v.exp_data);
      chk({nm, "_rstall_tag"}, lsu_resp_tag, v.tag);
    end
    lsu_resp_ready = 1;
    @(posedge clk); #1;
    lsu_resp_ready = 0;
    chk({nm, "_done_resp_valid"}, lsu_resp_valid, 0);
    chk({nm, "_done_busy"}, busy, 0);
  endtask

  initial begin
    int r0, cyc;
    //            op    addr           data           tag   ret            mdly rdly exp
    vecs[0] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 4'h3, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0000_0040, 32'h1234_5678, 4'h7, 32'hAAAA_AAAA, 0, 0, 32'h0000_0000};
    vecs[2] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF, 2, 3, 32'hFFFF_FFFF};
    vecs[3] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h0, 32'h5555_5555, 1, 1, 32'h0000_0000};
    vecs[4] = '{1'b0, 32'h0000_0008, 32'h1357_2468, 4'h9, 32'h0000_0000, 3, 0, 32'h0000_0000};

    idle_inputs();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready_low", lsu_req_ready, 0);
    chk("rst_resp_valid", lsu_resp_valid, 0);
    chk("rst_mreq_valid", memory_req_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outputs", {memory_req_op, memory_req_address, lsu_resp_tag}, 0);
    reset = 1;
    @(posedge clk); #1;
    chk("post_rst_req_ready", lsu_req_ready, 1);
    chk("post_rst_resp_data", lsu_resp_data, 0);

    // stray ack while idle
    memory_ack = 1; memory_data_return = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    memory_ack = 0;
    chk("stray_idle_resp_valid", lsu_resp_valid, 0);
    chk("stray_idle_busy", busy, 0);
    chk("stray_idle_mreq_valid", memory_req_valid, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // full queue under memory backpressure
    clear_model();
    idle_inputs();
    lsu_resp_ready = 1;
    for (int k = 0; k < 5; k++) begin
      bit acc;
      acc = 0;
      lsu_req_valid = 1; lsu_req_op = 0; lsu_req_tag = 4'(k);
      lsu_req_addr = 32'h200 + 32'(4 * k); lsu_req_data = $urandom;
      for (int t = 0; t < 10 && !acc; t++) begin
        drive_mem(1, 0, 0);
        acc = lsu_req_ready;
        tick();
      end
      chk($sformatf("full_push%0d_accepted", k), acc, 1);
    end
    chk("full_req_ready", lsu_req_ready, 0);
    chk("full_mreq_valid", memory_req_valid, 1);
    chk("full_mreq_addr_head", memory_req_address, 32'h200);
    lsu_req_tag = 4'd5;
    for (int t = 0; t < 3; t++) begin
      drive_mem(1, 0, 0);
      tick();
      chk("full_pending_blocked", lsu_req_ready, 0);
    end
    lsu_req_valid = 0;
    r0 = n_resp;
    for (cyc = 0; cyc < 200; cyc++) begin
      drive_mem(0, 0, 0);
      lsu_resp_ready = 1;
      tick();
      if (exp_resp.size() == 0 && !lsu_resp_valid) break;
    end
    chk("full_resp_count", n_resp - r0, 5);
    chk("full_drained_busy", busy, 0);

    // randomized traffic with memory and response stalls
    clear_model();
    idle_inputs();
    push_target = n_push + 80;
    r0 = n_resp;
    for (cyc = 0; cyc < 5000; cyc++) begin
      drive_lsu();
      drive_mem(0, 5, 1);
      drive_resp(3);
      tick();
      if (n_push == push_target && exp_resp.size() == 0 && !busy && !outst) break;
    end
    idle_inputs();
    chk("rand_pushes", n_push, push_target);
    chk("rand_resp_count", n_resp - r0, 80);
    chk("rand_queue_drained", exp_resp.size(), 0);

    // reset while waiting for an ack with two requests queued
    clear_model();
    idle_inputs();
    lsu_resp_ready = 1;
    r0 = n_push;
    for (int k = 0; k < 3; k++) begin
      lsu_req_valid = 1; lsu_req_op = 0; lsu_req_tag = 4'(10 + k);
      lsu_req_addr = 32'h300 + 32'(4 * k);
      drive_mem(1, 0, 0);
      tick();
    end
    lsu_req_valid = 0;
    chk("midop_pushes", n_push - r0, 3);
    drive_mem(0, 0, 0);
    tick();
    chk("midop_waiting_ack", outst, 1);
    chk("midop_busy", busy, 1);
    memory_ready = 0;
    reset = 0;
    #1;
    chk("midop_rst_req_ready", lsu_req_ready, 0);
    chk("midop_rst_resp_valid", lsu_resp_valid, 0);
    chk("midop_rst_mreq_valid", memory_req_valid, 0);
    chk("midop_rst_busy", busy, 0);
    chk("midop_rst_mreq_addr", memory_req_address, 0);
    chk("midop_rst_resp_fields", {lsu_resp_op, lsu_resp_tag, lsu_resp_data}, 0);
    clear_model();
    @(posedge clk); #1;
    reset = 1;
    memory_ack = 1; memory_data_return = 32'hFACE_F00D;
    @(posedge clk); #1;
    memory_ack = 0;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      chk("post_midop_resp_valid", lsu_resp_valid, 0);
      chk("post_midop_mreq_valid", memory_req_valid, 0);
      chk("post_midop_busy", busy, 0);
    end
    chk("post_midop_req_ready", lsu_req_ready, 1);
    run_vec(vecs[0], "fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule
